// File: rtl/pixel_stream_framer_pkg.sv
// Shared helpers for the pixel stream framer: effective-dimension rule and
// legal pixels-per-beat values.
package pixel_stream_framer_pkg;

  // Round the configured size down to the beat alignment; zero or oversize
  // configurations fall back to the maximum supported size.
  function automatic int eff_dim(input int cfg, input int max_dim, input int align);
    int r;
    r = (cfg / align) * align;
    return (r == 0 || r > max_dim) ? max_dim : r;
  endfunction

  function automatic bit ppb_legal(input int ppb);
    return (ppb == 1) || (ppb == 2) || (ppb == 4);
  endfunction

endpackage

// File: rtl/pixel_stream_framer_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full    = (level == LVW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pixel_stream_framer.sv
// Packs shaded pixels into video beats, tracks raster position against a
// per-frame resolution and buffers beats toward the video output stage.
module pixel_stream_framer
  import pixel_stream_framer_pkg::*;
#(
  parameter int MAX_WIDTH    = 640,
  parameter int MAX_HEIGHT   = 480,
  parameter int PIX_WIDTH    = 24,
  parameter int PIX_PER_BEAT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]      cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]     cfg_height,
  input  logic                                restart,
  input  logic [PIX_WIDTH-1:0]                in_pixel,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [PIX_WIDTH*PIX_PER_BEAT-1:0]   out_data,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
  localparam int XW = $clog2(MAX_WIDTH + 1);
  localparam int YW = $clog2(MAX_HEIGHT + 1);
  localparam int LW = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
  localparam int DW = PIX_WIDTH * PIX_PER_BEAT;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } pix_beat_t;

  if (!ppb_legal(PIX_PER_BEAT)) begin : g_bad_ppb
    $error("pixel_stream_framer: PIX_PER_BEAT must be 1, 2 or 4");
  end

  logic [XW-1:0] x, eff_w, eff_w_q;
  logic [YW-1:0] y, eff_h, eff_h_q;
  logic [LW-1:0] lane;
  logic [DW-1:0] part, beat_data;
  logic          beat_sof, at_start, xfer, last_lane, last_x, last_y, pix_sof, push;
  logic          fifo_full, fifo_empty, head_last, side_unused;
  logic          side_full, side_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] side_level;
  pix_beat_t     wr_beat, rd_beat;

  // Configuration is live only while the raster sits at the frame origin.
  assign at_start = (x == '0) && (y == '0) && (lane == '0);
  assign eff_w = at_start ? XW'(eff_dim(int'(cfg_width), MAX_WIDTH, PIX_PER_BEAT)) : eff_w_q;
  assign eff_h = at_start ? YW'(eff_dim(int'(cfg_height), MAX_HEIGHT, 1)) : eff_h_q;

  // Handshake: a transfer happens on any edge where valid && ready; ready never
  // depends on valid, and out_ready reaches in_ready only through the FIFO level.
  assign in_ready  = !rst && !fifo_full;
  assign xfer      = in_valid && in_ready && !restart;
  assign last_lane = (lane == LW'(PIX_PER_BEAT - 1));
  assign last_x    = (x == eff_w - XW'(1));
  assign last_y    = (y == eff_h - YW'(1));
  assign pix_sof   = (lane == '0) ? ((x == '0) && (y == '0)) : beat_sof;
  assign push      = xfer && last_lane;

  always_comb begin
    beat_data = part;
    beat_data[int'(lane)*PIX_WIDTH +: PIX_WIDTH] = in_pixel;
  end

  assign wr_beat = '{data: beat_data, sof: pix_sof, eol: last_x};

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      x        <= '0;
      y        <= '0;
      lane     <= '0;
      part     <= '0;
      beat_sof <= 1'b0;
    end else if (xfer) begin
      part     <= beat_data;
      beat_sof <= pix_sof;
      lane     <= last_lane ? '0 : lane + 1'b1;
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eff_w_q <= '0;
      eff_h_q <= '0;
    end else begin
      eff_w_q <= eff_w;
      eff_h_q <= eff_h;
    end
  end

  sync_fifo #(.WIDTH(DW + 2), .DEPTH(FIFO_DEPTH)) u_beat_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (restart),
    .wr_en   (push),
    .wr_data (wr_beat),
    .rd_en   (out_ready),
    .rd_data (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Marks the beat closing a frame; kept in lockstep with the beat FIFO.
  sync_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_end_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (restart),
    .wr_en   (push),
    .wr_data (last_x && last_y),
    .rd_en   (out_ready),
    .rd_data (head_last),
    .full    (side_full),
    .empty   (side_empty),
    .level   (side_level)
  );
  assign side_unused = ^{side_full, side_empty, side_level};

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? rd_beat.data : '0;
  assign out_sof   = out_valid && rd_beat.sof;
  assign out_eol   = out_valid && rd_beat.eol;

  always_ff @(posedge clk) begin
    if (rst || restart) frame_done <= 1'b0;
    else                frame_done <= out_valid && out_ready && head_last;
  end

endmodule
